// File: rtl/ps2_kbd_display_if.sv
// rtl/ps2_kbd_display_if.sv - board-side PS/2 pins and display outputs of the keyboard core
// Purpose: bundles the PS/2 input pair with the LED and 7-segment outputs.
// Signals:
//   ps2_clk, ps2_data : PS/2 clock/data from the board pins, asynchronous to clk
//   ledr[15:0]        : status LEDs
//   seg0..seg7[7:0]   : 7-segment digits, bit0=a..bit6=g, bit7=dp, active low
// Modports: master = board/environment side, slave = ps2_kbd_display core.
interface ps2_kbd_display_if;
   logic        ps2_clk;
   logic        ps2_data;
   logic [15:0] ledr;
   logic [7:0]  seg0;
   logic [7:0]  seg1;
   logic [7:0]  seg2;
   logic [7:0]  seg3;
   logic [7:0]  seg4;
   logic [7:0]  seg5;
   logic [7:0]  seg6;
   logic [7:0]  seg7;

   modport master (
      output ps2_clk, ps2_data,
      input  ledr, seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7
   );

   modport slave (
      input  ps2_clk, ps2_data,
      output ledr, seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7
   );
endinterface

// File: rtl/ps2_kbd_display.sv
// rtl/ps2_kbd_display.sv - PS/2 keyboard receiver, make/break decoder and LED/7-seg display
// Purpose: receives 11-bit PS/2 frames, decodes make/break scancodes, shows key status.
// Ports:
//   clk    : system clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : ps2_kbd_display_if.slave (ps2_clk/ps2_data in, ledr/seg0..seg7 out)
// Parameter: TIMEOUT_CYCLES - idle clk cycles before a partial frame is aborted.
// Macro: PS2_PARITY_CHECK_EN - when defined, frames with bad odd parity are rejected.
module ps2_kbd_display #(
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic               clk,
   input  logic               resetn,
   ps2_kbd_display_if.slave   bus
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   function automatic logic [7:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
         4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
         4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
         4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
      endcase
   endfunction

   // receiver state
   logic [2:0]    sync_q, sync_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [9:0]    shift_q, shift_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          byte_valid_q, byte_valid_d;
   logic          frame_err_q, frame_err_d;
   logic [7:0]    rx_byte_q, rx_byte_d;
   // decoder state
   logic [7:0]    key_code_q, key_code_d;
   logic [7:0]    press_cnt_q, press_cnt_d;
   logic [7:0]    last_byte_q, last_byte_d;
   logic          held_q, held_d, brk_q, brk_d, ext_q, ext_d, err_q, err_d;
   // output registers
   logic [15:0]   ledr_q, ledr_d;
   logic [7:0]    seg0_q, seg0_d, seg1_q, seg1_d, seg4_q, seg4_d;
   logic [7:0]    seg5_q, seg5_d, seg6_q, seg6_d, seg7_q, seg7_d;

   logic fall, par_ok;

   assign fall = (sync_q[2:1] == 2'b10);

   // shift_q[0]=start, shift_q[8:1]=data, shift_q[9]=parity; stop bit is live ps2_data
`ifdef PS2_PARITY_CHECK_EN
   assign par_ok = ^shift_q[9:1];
`else
   assign par_ok = 1'b1;
`endif

   always_comb begin
      sync_d       = {sync_q[1:0], bus.ps2_clk};
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      to_cnt_d     = to_cnt_q;
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      rx_byte_d    = rx_byte_q;

      // data is stable around the falling edge, so it is sampled directly on the detect cycle
      if (fall) begin
         to_cnt_d = '0;
         if (bit_cnt_q == 4'd10) begin
            bit_cnt_d = 4'd0;
            if (!shift_q[0] && bus.ps2_data && par_ok) begin
               byte_valid_d = 1'b1;
               rx_byte_d    = shift_q[8:1];
            end else begin
               frame_err_d = 1'b1;
            end
         end else begin
            shift_d[bit_cnt_q] = bus.ps2_data;
            bit_cnt_d          = bit_cnt_q + 4'd1;
         end
      end else if (bit_cnt_q != 4'd0) begin
         if (to_cnt_q == TO_LAST) begin
            bit_cnt_d = 4'd0;
            to_cnt_d  = '0;
            shift_d   = '0;
         end else begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end else begin
         to_cnt_d = '0;
      end
   end

   always_comb begin
      key_code_d  = key_code_q;
      press_cnt_d = press_cnt_q;
      last_byte_d = last_byte_q;
      held_d      = held_q;
      brk_d       = brk_q;
      ext_d       = ext_q;
      err_d       = err_q;

      if (frame_err_q) err_d = 1'b1;

      if (byte_valid_q) begin
         err_d       = 1'b0;
         last_byte_d = rx_byte_q;
         if (rx_byte_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (rx_byte_q == 8'hF0) begin
            brk_d = 1'b1;
         end else if (brk_q) begin
            // release of a key other than the held one leaves the held key shown
            if (rx_byte_q == key_code_q) held_d = 1'b0;
            brk_d = 1'b0;
            ext_d = 1'b0;
         end else begin
            // a repeated make of the held key is typematic and does not count
            if (!held_q || rx_byte_q != key_code_q) begin
               key_code_d  = rx_byte_q;
               held_d      = 1'b1;
               press_cnt_d = press_cnt_q + 8'd1;
            end
            ext_d = 1'b0;
         end
      end
   end

   always_comb begin
      seg0_d = held_q ? hex7(key_code_q[3:0]) : 8'hFF;
      seg1_d = held_q ? hex7(key_code_q[7:4]) : 8'hFF;
      seg4_d = hex7(press_cnt_q[3:0]);
      seg5_d = hex7(press_cnt_q[7:4]);
      seg6_d = hex7(last_byte_q[3:0]);
      seg7_d = hex7(last_byte_q[7:4]);
      ledr_d = {4'b0000, err_q, ext_q, brk_q, held_q, last_byte_q};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q       <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         to_cnt_q     <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         rx_byte_q    <= '0;
         key_code_q   <= '0;
         press_cnt_q  <= '0;
         last_byte_q  <= '0;
         held_q       <= 1'b0;
         brk_q        <= 1'b0;
         ext_q        <= 1'b0;
         err_q        <= 1'b0;
         ledr_q       <= '0;
         seg0_q       <= 8'hFF;
         seg1_q       <= 8'hFF;
         seg4_q       <= 8'hC0;
         seg5_q       <= 8'hC0;
         seg6_q       <= 8'hC0;
         seg7_q       <= 8'hC0;
      end else begin
         sync_q       <= sync_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         to_cnt_q     <= to_cnt_d;
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
         rx_byte_q    <= rx_byte_d;
         key_code_q   <= key_code_d;
         press_cnt_q  <= press_cnt_d;
         last_byte_q  <= last_byte_d;
         held_q       <= held_d;
         brk_q        <= brk_d;
         ext_q        <= ext_d;
         err_q        <= err_d;
         ledr_q       <= ledr_d;
         seg0_q       <= seg0_d;
         seg1_q       <= seg1_d;
         seg4_q       <= seg4_d;
         seg5_q       <= seg5_d;
         seg6_q       <= seg6_d;
         seg7_q       <= seg7_d;
      end
   end

   assign bus.ledr = ledr_q;
   assign bus.seg0 = seg0_q;
   assign bus.seg1 = seg1_q;
   assign bus.seg2 = 8'hFF;
   assign bus.seg3 = 8'hFF;
   assign bus.seg4 = seg4_q;
   assign bus.seg5 = seg5_q;
   assign bus.seg6 = seg6_q;
   assign bus.seg7 = seg7_q;

endmodule

// File: tb/tb_ps2_kbd_display.sv
// tb/tb_ps2_kbd_display.sv - directed self-checking bench for ps2_kbd_display
module tb_ps2_kbd_display;

   localparam int TO   = 300;
   localparam int HALF = 8;

   logic clk;
   logic resetn;
   int   n_checks;
   int   n_fail;

   ps2_kbd_display_if bus ();

   ps2_kbd_display #(.TIMEOUT_CYCLES(TO)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %04h expected %04h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par_bad,
                                            input logic stop);
      return {stop, (~^d) ^ par_bad, d, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         bus.ps2_data = f[i];
         repeat (HALF) @(negedge clk);
         bus.ps2_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         bus.ps2_clk = 1'b1;
      end
      bus.ps2_data = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] d);
      send_bits(mk_frame(d, 1'b0, 1'b1), 0, 10);
      repeat (20) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      resetn       = 1'b0;
      repeat (3) @(negedge clk);

      // reset values
      check_val("rst_ledr", bus.ledr, 16'h0000);
      check_val("rst_seg0", {8'h0, bus.seg0}, 16'h00FF);
      check_val("rst_seg1", {8'h0, bus.seg1}, 16'h00FF);
      check_val("rst_seg2", {8'h0, bus.seg2}, 16'h00FF);
      check_val("rst_seg3", {8'h0, bus.seg3}, 16'h00FF);
      check_val("rst_seg4", {8'h0, bus.seg4}, 16'h00C0);
      check_val("rst_seg7", {8'h0, bus.seg7}, 16'h00C0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // make 1C
      send_byte(8'h1C);
      check_val("mk_seg0", {8'h0, bus.seg0}, 16'h00C6);
      check_val("mk_seg1", {8'h0, bus.seg1}, 16'h00F9);
      check_val("mk_seg4", {8'h0, bus.seg4}, 16'h00F9);
      check_val("mk_seg5", {8'h0, bus.seg5}, 16'h00C0);
      check_val("mk_ledr", bus.ledr, 16'h011C);

      // break F0,1C
      send_byte(8'hF0);
      check_val("f0_ledr", bus.ledr, 16'h03F0);
      send_byte(8'h1C);
      check_val("brk_ledr", bus.ledr, 16'h001C);
      check_val("brk_seg0", {8'h0, bus.seg0}, 16'h00FF);
      check_val("brk_seg1", {8'h0, bus.seg1}, 16'h00FF);
      check_val("brk_seg4", {8'h0, bus.seg4}, 16'h00F9);
      check_val("brk_seg6", {8'h0, bus.seg6}, 16'h00C6);
      check_val("brk_seg7", {8'h0, bus.seg7}, 16'h00F9);

      // typematic repeats then re-press after release
      do_reset();
      send_byte(8'h1C);
      send_byte(8'h1C);
      send_byte(8'h1C);
      check_val("typ_seg4", {8'h0, bus.seg4}, 16'h00F9);
      send_byte(8'hF0);
      send_byte(8'h1C);
      send_byte(8'h1C);
      check_val("repress_seg4", {8'h0, bus.seg4}, 16'h00A4);
      check_val("repress_ledr", bus.ledr, 16'h011C);

      // bad parity
      do_reset();
      send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 0, 10);
      repeat (20) @(negedge clk);
`ifdef PS2_PARITY_CHECK_EN
      check_val("par_ledr", bus.ledr, 16'h0800);
      check_val("par_seg4", {8'h0, bus.seg4}, 16'h00C0);
`else
      check_val("par_ledr", bus.ledr, 16'h011C);
      check_val("par_seg4", {8'h0, bus.seg4}, 16'h00F9);
`endif

      // bad stop bit is rejected in both builds; next valid frame clears err
      do_reset();
      send_byte(8'h1C);
      send_bits(mk_frame(8'h32, 1'b0, 1'b0), 0, 10);
      repeat (20) @(negedge clk);
      check_val("stop_ledr", bus.ledr, 16'h091C);
      check_val("stop_seg0", {8'h0, bus.seg0}, 16'h00C6);
      send_byte(8'hF0);
      check_val("errclr_ledr", bus.ledr, 16'h03F0);

      // extended prefix
      do_reset();
      send_byte(8'hE0);
      check_val("ext_ledr", bus.ledr, 16'h04E0);
      check_val("ext_seg7", {8'h0, bus.seg7}, 16'h0086);
      send_byte(8'h75);
      check_val("ext_mk_ledr", bus.ledr, 16'h0175);
      check_val("ext_mk_seg0", {8'h0, bus.seg0}, 16'h0092);
      check_val("ext_mk_seg1", {8'h0, bus.seg1}, 16'h00F8);

      // timeout aborts a partial frame
      do_reset();
      send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 0, 4);
      repeat (TO + 50) @(negedge clk);
      send_byte(8'h32);
      check_val("to_ledr", bus.ledr, 16'h0132);
      check_val("to_seg0", {8'h0, bus.seg0}, 16'h00A4);
      check_val("to_seg1", {8'h0, bus.seg1}, 16'h00B0);

      // a gap shorter than the timeout keeps the partial frame
      do_reset();
      send_bits(mk_frame(8'h32, 1'b0, 1'b1), 0, 4);
      repeat (TO - 60) @(negedge clk);
      send_bits(mk_frame(8'h32, 1'b0, 1'b1), 5, 10);
      repeat (20) @(negedge clk);
      check_val("gap_ledr", bus.ledr, 16'h0132);

      // reset mid-frame
      do_reset();
      send_byte(8'hE0);
      send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 0, 3);
      do_reset();
      check_val("midrst_ledr", bus.ledr, 16'h0000);
      send_byte(8'h1C);
      check_val("midrst_dec_ledr", bus.ledr, 16'h011C);
      check_val("midrst_seg4", {8'h0, bus.seg4}, 16'h00F9);
      check_val("midrst_seg6", {8'h0, bus.seg6}, 16'h00C6);
      check_val("midrst_seg7", {8'h0, bus.seg7}, 16'h00F9);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
